lag_window_apply: RTL and testbench
===================================

# lag_window_apply

Reads the 11 autocorrelation coefficients r[0..10] that the autocorrelation block leaves in scratch memory at AUTOCORR_R, and applies the G.729 lag window. Coefficients r[1..10] are multiplied by the fixed lag constants in double-precision (Mpy_32) arithmetic. It writes the 11 windowed coefficients to LAG_WINDOW_R. It sits between the autocorrelation block and Levinson-Durbin and is the consumer end of the autocorrelation result interface.

## Interface
- AUTOCORR_R, paramList value, 11-bit base address of the r[0..10] input words; bits [3:0] of the base are 0.
- LAG_WINDOW_R, paramList value, 11-bit base address of the output words; bits [3:0] of the base are 0.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  level; sampled only in IDLE.
- memIn  in  32  read data from scratch memory; valid one cycle after memReadAddr is presented.
- memReadAddr  out  11  {AUTOCORR_R[10:4], i[3:0]}.
- memWriteAddr  out  11  {LAG_WINDOW_R[10:4], i[3:0]}.
- memOut  out  32  windowed coefficient.
- memWrite  out  1  write strobe, one cycle per coefficient.
- done  out  1  level; high from completion until the next accepted start.

## Operation
- FSM states:
  - IDLE
  - RD: drive memReadAddr for index i.
  - WT: memory latency cycle.
  - CALC: latch memIn, compute, register the result.
  - WR: memWrite=1, memWriteAddr and memOut valid.
  - DONE
- Transitions:
  - IDLE→RD when start=1. Clear i to 0 and done to 0.
  - RD→WT→CALC→WR.
  - WR→RD with i+1 while i<10.
  - WR→DONE when i=10.
  - DONE→RD when start=1 (restart with i=0). Otherwise stay in DONE with done=1.
- i=0: memOut = memIn, unmodified.
- i=1..10, with r = memIn:
  - hi = r[31:16] (signed).
  - lo = r[15:1] zero-extended (L_Extract).
  - lag_h/lag_l come from an internal 10-entry ROM indexed by i-1:
    - lag_h = 32728, 32619, 32438, 32187, 31867, 31480, 31029, 30517, 29946, 29321
    - lag_l = 11904, 17280, 30720, 25856, 24192, 28992, 24384, 7360, 19520, 14784
  - result = sat32( 2·(hi·lag_h) + 2·((hi·lag_l)>>>15) + 2·((lo·lag_h)>>>15) ).
  - All products are signed 32-bit. >>> is an arithmetic shift. Each accumulation step saturates to [0x80000000, 0x7FFFFFFF] (L_mac semantics).
- Memory accesses are only to the 11 read and 11 write addresses. Nothing is written outside LAG_WINDOW_R+0..10.
- In-place operation (AUTOCORR_R == LAG_WINDOW_R) is legal, because each word is read before it is written.

## Timing
- Reset values: memWrite=0, done=0, memOut=0, memReadAddr={AUTOCORR_R[10:4],4'd0}, memWriteAddr={LAG_WINDOW_R[10:4],4'd0}, state IDLE, i=0.
- Each coefficient takes 4 cycles. Counting from the edge that samples start as edge 0, memWrite for index i is high in the cycle following edge 4i+3.
- done rises at edge 44. Total latency is 44 cycles, plus done.
- memWrite is never asserted outside WR. Exactly 11 memWrite pulses occur per run.
- start while busy (RD/WT/CALC/WR) is ignored. start held high in DONE restarts immediately.
- Reset mid-run returns to IDLE on the next edge. memWrite=0 and done=0 at that edge. Partial results already written stay in memory. A later start reprocesses all 11 coefficients from i=0.
- Reset has priority over start when both are high.

## Test plan
- Memory preloaded with r[0]=0x12345678 and r[1..10]=0x00010000; pulse start. Required results:
  - out[0]=0x12345678 and out[1]=0x0000FFB0.
  - Exactly 11 memWrite pulses.
  - done high 44 cycles after start.
- r[1]=0xFFFF0000 → out[1]=0xFFFF004E. This checks the arithmetic shift of a negative product.
- r[1]=0x7FFFFFFF → out[1]=0x7FD85CFC. r[10]=0x00000000 → out[10]=0x00000000.
- Reset asserted at edge 20 of a run:
  - memWrite=0 and done=0 from the next edge; the block stays idle.
  - A second start produces all 11 correct results.
- start re-pulsed at edge 10 of a run is ignored: done still rises at edge 44. Then start held high in DONE launches a second run that clears done.
- Run the 120 ITU G.729 test-vector frames (lsp_autocorr_out.out as input) back-to-back. All 1320 output words must match the reference lag-window vectors.

Source files
------------

// File: rtl/lag_window_apply.sv
// Applies the G.729 lag window to r[0..10] read from scratch memory, writing the
// windowed coefficients back out; r[0] passes through, r[1..10] use Mpy_32 arithmetic.
module lag_window_apply #(
    parameter logic [10:0] AUTOCORR_R   = 11'h000,
    parameter logic [10:0] LAG_WINDOW_R = 11'h010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] memIn,
    output logic [10:0] memReadAddr,
    output logic [10:0] memWriteAddr,
    output logic [31:0] memOut,
    output logic        memWrite,
    output logic        done
);

    localparam int DATA_W = 32;
    localparam int COEF_W = 16;

    typedef enum logic [2:0] {IDLE, RD, WT, CALC, WR, DONE} state_t;

    state_t     state;
    logic [3:0] i;

    assign memReadAddr  = {AUTOCORR_R[10:4], i};
    assign memWriteAddr = {LAG_WINDOW_R[10:4], i};

    function automatic logic signed [COEF_W-1:0] lag_h(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'sd32728;
            4'd1:    return 16'sd32619;
            4'd2:    return 16'sd32438;
            4'd3:    return 16'sd32187;
            4'd4:    return 16'sd31867;
            4'd5:    return 16'sd31480;
            4'd6:    return 16'sd31029;
            4'd7:    return 16'sd30517;
            4'd8:    return 16'sd29946;
            4'd9:    return 16'sd29321;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic logic signed [COEF_W-1:0] lag_l(input logic [3:0] idx);
        case (idx)
            4'd0:    return 16'sd11904;
            4'd1:    return 16'sd17280;
            4'd2:    return 16'sd30720;
            4'd3:    return 16'sd25856;
            4'd4:    return 16'sd24192;
            4'd5:    return 16'sd28992;
            4'd6:    return 16'sd24384;
            4'd7:    return 16'sd7360;
            4'd8:    return 16'sd19520;
            4'd9:    return 16'sd14784;
            default: return 16'sd0;
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] sat32(input logic signed [DATA_W+1:0] v);
        if (v > 34'sh0_7FFF_FFFF)
            return 32'sh7FFF_FFFF;
        else if (v < $signed(34'h3_8000_0000))
            return 32'sh8000_0000;
        else
            return v[DATA_W-1:0];
    endfunction

    // Mpy_32 of the DPF-split coefficient with the DPF lag constant; every accumulate saturates.
    function automatic logic signed [DATA_W-1:0] lag_mpy(input logic [DATA_W-1:0] r,
                                                         input logic [3:0] idx);
        logic signed [COEF_W-1:0] hi, lo, lh, ll;
        logic signed [DATA_W-1:0] p_hh, p_hl, p_lh, acc;
        hi   = signed'(r[31:16]);
        lo   = signed'({1'b0, r[15:1]});
        lh   = lag_h(idx);
        ll   = lag_l(idx);
        p_hh = 32'(hi) * 32'(lh);
        p_hl = 32'(hi) * 32'(ll);
        p_lh = 32'(lo) * 32'(lh);
        acc  = sat32(34'(p_hh) <<< 1);
        acc  = sat32(34'(acc) + (34'(p_hl >>> 15) <<< 1));
        acc  = sat32(34'(acc) + (34'(p_lh >>> 15) <<< 1));
        return acc;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            i        <= 4'd0;
            memWrite <= 1'b0;
            done     <= 1'b0;
            memOut   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RD;
                        i     <= 4'd0;
                        done  <= 1'b0;
                    end
                end
                RD: state <= WT;
                WT: state <= CALC;
                // memIn holds the word for index i here since the read address is still stable
                CALC: begin
                    memOut   <= (i == 4'd0) ? memIn : lag_mpy(memIn, 4'(i - 4'd1));
                    memWrite <= 1'b1;
                    state    <= WR;
                end
                WR: begin
                    memWrite <= 1'b0;
                    if (i == 4'd10) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        i     <= i + 4'd1;
                        state <= RD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lag_window_apply.sv
// Scoreboard bench for lag_window_apply: a behavioural scratch memory, a G.729
// basic-op reference model, and per-scenario tasks run in sequence.
module tb_lag_window_apply;

    localparam logic [10:0] AC_BASE = 11'h100;
    localparam logic [10:0] LW_BASE = 11'h200;
    localparam longint MAXL = 64'sd2147483647;
    localparam longint MINL = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] memIn;
    logic [10:0] memReadAddr;
    logic [10:0] memWriteAddr;
    logic [31:0] memOut;
    logic        memWrite;
    logic        done;

    lag_window_apply #(.AUTOCORR_R(AC_BASE), .LAG_WINDOW_R(LW_BASE)) dut (
        .clk(clk), .reset(reset), .start(start), .memIn(memIn),
        .memReadAddr(memReadAddr), .memWriteAddr(memWriteAddr),
        .memOut(memOut), .memWrite(memWrite), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] src[16];
    logic [31:0] outmem[16];
    int          stray = 0;

    always @(posedge clk) begin
        if (memReadAddr[10:4] == AC_BASE[10:4]) memIn <= src[memReadAddr[3:0]];
        else memIn <= 32'hBAD0_BAD0;
        if (memWrite) begin
            if (memWriteAddr[10:4] == LW_BASE[10:4]) outmem[memWriteAddr[3:0]] <= memOut;
            else stray <= stray + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   total  = 0;

    int lag_h_t[10] = '{32728, 32619, 32438, 32187, 31867, 31480, 31029, 30517, 29946, 29321};
    int lag_l_t[10] = '{11904, 17280, 30720, 25856, 24192, 28992, 24384, 7360, 19520, 14784};

    function automatic int l_sat(longint v);
        if (v > MAXL) return int'(MAXL);
        if (v < MINL) return int'(MINL);
        return int'(v);
    endfunction

    function automatic int l_mult(int a, int b);
        return l_sat(longint'(a) * longint'(b) * 2);
    endfunction

    function automatic int mult16(int a, int b);
        longint p = (longint'(a) * longint'(b)) >>> 15;
        if (p > 32767) return 32767;
        if (p < -32768) return -32768;
        return int'(p);
    endfunction

    function automatic int l_mac(int acc, int a, int b);
        return l_sat(longint'(acc) + longint'(l_mult(a, b)));
    endfunction

    function automatic int mpy_32(int hi1, int lo1, int hi2, int lo2);
        int l;
        l = l_mult(hi1, hi2);
        l = l_mac(l, mult16(hi1, lo2), 1);
        l = l_mac(l, mult16(lo1, hi2), 1);
        return l;
    endfunction

    function automatic logic [31:0] model_win(logic [31:0] r, int idx);
        int hi, lo;
        hi = int'($signed(r[31:16]));
        lo = int'({1'b0, r[15:1]});
        return 32'(mpy_32(hi, lo, lag_h_t[idx-1], lag_l_t[idx-1]));
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int n = 0; n < 11; n++) begin
            e.addr = LW_BASE + 11'(n);
            e.data = (n == 0) ? src[0] : model_win(src[n], n);
            sbq.push_back(e);
        end
    endtask

    task automatic fill_random();
        for (int n = 0; n < 11; n++) begin
            case ($urandom_range(0, 5))
                0:       src[n] = 32'h7FFF_FFFF;
                1:       src[n] = 32'h8000_0000;
                2:       src[n] = 32'h0000_0000;
                default: src[n] = $urandom;
            endcase
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after edge 0; k counts edges since start was sampled.
    task automatic watch(input string tag, input int max_k, input int repulse_k,
                         input bit expect_done, output int done_k, output int writes);
        exp_t e;
        done_k = -1;
        writes = 0;
        for (int k = 0; k <= max_k; k++) begin
            if (k == repulse_k) start = 1'b1;
            else if (k == repulse_k + 1) start = 1'b0;
            if (memWrite) begin
                total++;
                if (k != 4 * writes + 3)
                    $display("FAIL %s_write_timing: write %0d at edge %0d, required edge %0d",
                             tag, writes, k, 4 * writes + 3);
                else passed++;
                total++;
                if (sbq.size() == 0) begin
                    $display("FAIL %s_extra_write: got addr %h data %h, required no write",
                             tag, memWriteAddr, memOut);
                end else begin
                    e = sbq.pop_front();
                    if ({memWriteAddr, memOut} !== {e.addr, e.data})
                        $display("FAIL %s_data: got addr %h data %h, required addr %h data %h",
                                 tag, memWriteAddr, memOut, e.addr, e.data);
                    else passed++;
                end
                writes++;
            end
            if (done) begin
                done_k = k;
                break;
            end
            if (k < max_k) @(negedge clk);
        end
        if (expect_done && done_k < 0) begin
            total++;
            $display("FAIL %s_timeout: got no done within %0d edges, required done", tag, max_k);
        end
    endtask

    task automatic check_run(input string tag, input int done_k, input int writes);
        total++;
        if (done_k != 44) $display("FAIL %s_done_edge: got %0d required 44", tag, done_k);
        else passed++;
        total++;
        if (writes != 11) $display("FAIL %s_write_count: got %0d required 11", tag, writes);
        else passed++;
    endtask

    task automatic test_reset();
        logic seen;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (memWrite !== 1'b0) $display("FAIL rst_memWrite: got %b required 0", memWrite);
        else passed++;
        total++;
        if (done !== 1'b0) $display("FAIL rst_done: got %b required 0", done);
        else passed++;
        total++;
        if (memOut !== 32'h0) $display("FAIL rst_memOut: got %h required 0", memOut);
        else passed++;
        total++;
        if (memReadAddr !== {AC_BASE[10:4], 4'd0})
            $display("FAIL rst_rdaddr: got %h required %h", memReadAddr, {AC_BASE[10:4], 4'd0});
        else passed++;
        total++;
        if (memWriteAddr !== {LW_BASE[10:4], 4'd0})
            $display("FAIL rst_wraddr: got %h required %h", memWriteAddr, {LW_BASE[10:4], 4'd0});
        else passed++;
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (memWrite !== 1'b0 || done !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) $display("FAIL rst_idle: got activity without start, required none");
        else passed++;
    endtask

    task automatic test_basic();
        int dk, wr;
        src[0] = 32'h1234_5678;
        for (int n = 1; n < 11; n++) src[n] = 32'h0001_0000;
        push_frame();
        pulse_start();
        watch("basic", 60, -1, 1'b1, dk, wr);
        check_run("basic", dk, wr);
        total++;
        if (outmem[0] !== 32'h1234_5678) $display("FAIL basic_out0: got %h required 12345678", outmem[0]);
        else passed++;
        total++;
        if (outmem[1] !== 32'h0000_FFB0) $display("FAIL basic_out1: got %h required 0000ffb0", outmem[1]);
        else passed++;
    endtask

    task automatic test_boundary();
        int dk, wr;
        fill_random();
        src[1]  = 32'hFFFF_0000;
        src[10] = 32'h0000_0000;
        push_frame();
        pulse_start();
        watch("neg", 60, -1, 1'b1, dk, wr);
        check_run("neg", dk, wr);
        total++;
        if (outmem[1] !== 32'hFFFF_004E) $display("FAIL neg_out1: got %h required ffff004e", outmem[1]);
        else passed++;
        total++;
        if (outmem[10] !== 32'h0) $display("FAIL zero_out10: got %h required 00000000", outmem[10]);
        else passed++;
        fill_random();
        src[1] = 32'h7FFF_FFFF;
        src[2] = 32'h8000_0000;
        push_frame();
        pulse_start();
        watch("max", 60, -1, 1'b1, dk, wr);
        check_run("max", dk, wr);
        total++;
        if (outmem[1] !== 32'h7FD8_5CFC) $display("FAIL max_out1: got %h required 7fd85cfc", outmem[1]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int  dk, wr;
        logic seen;
        fill_random();
        push_frame();
        pulse_start();
        watch("mid", 19, -1, 1'b0, dk, wr);
        total++;
        if (wr != 5) $display("FAIL mid_partial_writes: got %0d required 5", wr);
        else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (memWrite !== 1'b0 || done !== 1'b0)
            $display("FAIL mid_reset_outputs: got memWrite %b done %b required 0 0", memWrite, done);
        else passed++;
        reset = 1'b0;
        sbq.delete();
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (memWrite !== 1'b0 || done !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) $display("FAIL mid_stay_idle: got activity after reset, required none");
        else passed++;
        push_frame();
        pulse_start();
        watch("mid_rerun", 60, -1, 1'b1, dk, wr);
        check_run("mid_rerun", dk, wr);
    endtask

    task automatic test_ignore_start();
        int dk, wr;
        fill_random();
        push_frame();
        pulse_start();
        watch("busy_start", 60, 9, 1'b1, dk, wr);
        check_run("busy_start", dk, wr);
        push_frame();
        pulse_start();
        total++;
        if (done !== 1'b0) $display("FAIL held_start_done_clear: got %b required 0", done);
        else passed++;
        watch("held_start", 60, -1, 1'b1, dk, wr);
        check_run("held_start", dk, wr);
    endtask

    task automatic test_back_to_back();
        int dk, wr;
        for (int f = 0; f < 20; f++) begin
            fill_random();
            push_frame();
            pulse_start();
            watch("b2b", 60, -1, 1'b1, dk, wr);
            check_run("b2b", dk, wr);
        end
    endtask

    initial begin
        for (int n = 0; n < 16; n++) begin
            src[n]    = 32'h0;
            outmem[n] = 32'h0;
        end
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_basic();
        test_boundary();
        test_reset_mid();
        test_ignore_start();
        test_back_to_back();
        total++;
        if (stray != 0) $display("FAIL stray_writes: got %0d required 0", stray);
        else passed++;
        total++;
        if (sbq.size() != 0) $display("FAIL leftover_expected: got %0d required 0", sbq.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
